// File: rtl/hamming_enc_inject.sv
// Hamming(2^R-1) encoder with one output register stage and periodic single-bit error injection.
// Define HAMMING_SECDED_EN to add an overall even-parity bit at out_code_o[0].
module hamming_enc_inject #(
  parameter int R     = 4,
  parameter int CNT_W = 8,
  localparam int N    = (1 << R) - 1,
  localparam int K    = N - R,
`ifdef HAMMING_SECDED_EN
  localparam int LSB  = 0
`else
  localparam int LSB  = 1
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [K-1:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N:LSB]     out_code_o,
  output logic             out_inj_o,
  input  logic             cfg_inj_en_i,
  input  logic [R-1:0]     cfg_inj_pos_i,
  input  logic [CNT_W-1:0] cfg_inj_period_i,
  output logic [15:0]      stat_inj_cnt_o,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  // Handshake: a word moves when valid && ready on the same rising edge; the output
  // register accepts a new word whenever it is empty or being drained this cycle.
  logic             out_valid_q, out_valid_d;
  logic [N:LSB]     out_code_q, out_code_d;
  logic             out_inj_q, out_inj_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stat_q, stat_d;

  logic             accept;
  logic [N:1]       placed;
  logic [N:1]       enc_code;
  logic [N:1]       flip;
  logic [N:LSB]     code_ext;
  logic [N:LSB]     flip_ext;
  logic [CNT_W-1:0] period_m1;
  logic             inj_hit;
  logic             inj_flag;
  int               di;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Data bits fill the non-power-of-two positions in ascending order.
  always_comb begin
    placed = '0;
    di     = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        placed[p] = in_data_i[di];
        di        = di + 1;
      end
    end
  end

  always_comb begin
    enc_code = placed;
    for (int i = 0; i < R; i++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if (((p >> i) & 1) == 1) par = par ^ placed[p];
      end
      enc_code[1 << i] = par;
    end
  end

  // A zero period behaves like one: every word hits.
  assign period_m1 = (cfg_inj_period_i == '0) ? '0 : cfg_inj_period_i - CNT_W'(1);
  assign inj_hit   = cfg_inj_en_i && (cnt_q >= period_m1);
  assign inj_flag  = inj_hit && (cfg_inj_pos_i != '0);

  always_comb begin
    flip = '0;
    for (int p = 1; p <= N; p++) begin
      flip[p] = inj_flag && (cfg_inj_pos_i == R'(p));
    end
  end

  // Overall parity is taken before the flip so any injected error shows as a single error.
`ifdef HAMMING_SECDED_EN
  assign code_ext = {enc_code, ^enc_code};
  assign flip_ext = {flip, 1'b0};
`else
  assign code_ext = enc_code;
  assign flip_ext = flip;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_inj_d   = out_inj_q;
    cnt_d       = cnt_q;
    stat_d      = stat_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_code_d  = code_ext ^ flip_ext;
      out_inj_d   = inj_flag;
      if (inj_flag && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (!cfg_inj_en_i) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = inj_hit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_inj_q   <= 1'b0;
      cnt_q       <= '0;
      stat_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_inj_q   <= out_inj_d;
      cnt_q       <= cnt_d;
      stat_q      <= stat_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_code_o     = out_code_q;
  assign out_inj_o      = out_inj_q;
  assign stat_inj_cnt_o = stat_q;
  assign dbg_cnt_o      = cnt_q;

endmodule

// File: tb/tb_hamming_enc_inject.sv
// Directed bench for hamming_enc_inject (R=4, CNT_W=8); inputs change on the falling edge,
// outputs are sampled on the next falling edge.
module tb_hamming_enc_inject;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
`ifdef HAMMING_SECDED_EN
  logic [15:0] out_code;
`else
  logic [15:1] out_code;
`endif
  logic        out_inj;
  logic        cfg_inj_en;
  logic [3:0]  cfg_inj_pos;
  logic [7:0]  cfg_inj_period;
  logic [15:0] stat_inj_cnt;
  logic [7:0]  dbg_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_enc_inject #(.R(4), .CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_code_o      (out_code),
    .out_inj_o       (out_inj),
    .cfg_inj_en_i    (cfg_inj_en),
    .cfg_inj_pos_i   (cfg_inj_pos),
    .cfg_inj_period_i(cfg_inj_period),
    .stat_inj_cnt_o  (stat_inj_cnt),
    .dbg_cnt_o       (dbg_cnt)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_inj_en = 1'b0; cfg_inj_pos = '0; cfg_inj_period = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_code[15:1] !== 15'h0000) begin errors++; $display("FAIL reset_code got %h exp 0", out_code); end
    checks++; if (out_inj !== 1'b0) begin errors++; $display("FAIL reset_inj got %b exp 0", out_inj); end
    checks++; if (stat_inj_cnt !== 16'h0) begin errors++; $display("FAIL reset_stat got %h exp 0", stat_inj_cnt); end
    checks++; if (dbg_cnt !== 8'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", dbg_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_encode();
    logic [10:0] vec_d [5] = '{11'h000, 11'h7FF, 11'h001, 11'h002, 11'h400};
    logic [14:0] vec_c [5] = '{15'h0000, 15'h7FFF, 15'h0007, 15'h0019, 15'h408B};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = vec_d[i];
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_code[15:1] !== vec_c[i]) begin errors++; $display("FAIL enc_code[%0d] got %h exp %h", i, out_code[15:1], vec_c[i]); end
      checks++; if (out_inj !== 1'b0) begin errors++; $display("FAIL enc_inj[%0d] got %b exp 0", i, out_inj); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_inject();
    logic exp_inj;
    logic [14:0] exp_code;
    cfg_inj_en = 1'b1; cfg_inj_pos = 4'd5; cfg_inj_period = 8'd3;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_data = 11'h000;
      @(negedge clk);
      exp_inj  = (k == 2) || (k == 5);
      exp_code = exp_inj ? 15'h0010 : 15'h0000;
      checks++; if (out_inj !== exp_inj) begin errors++; $display("FAIL inj_flag[%0d] got %b exp %b", k, out_inj, exp_inj); end
      checks++; if (out_code[15:1] !== exp_code) begin errors++; $display("FAIL inj_code[%0d] got %h exp %h", k, out_code[15:1], exp_code); end
      if (k == 5) begin
        checks++; if (stat_inj_cnt !== 16'd2) begin errors++; $display("FAIL inj_stat got %0d exp 2", stat_inj_cnt); end
      end
    end
    in_valid = 1'b0;
    checks++; if (dbg_cnt !== 8'd1) begin errors++; $display("FAIL inj_cnt_after7 got %0d exp 1", dbg_cnt); end
    cfg_inj_en = 1'b0;
    @(negedge clk);
    checks++; if (dbg_cnt !== 8'd0) begin errors++; $display("FAIL inj_cnt_clear got %0d exp 0", dbg_cnt); end
  endtask

  task automatic test_pos_zero_period_zero();
    cfg_inj_en = 1'b1; cfg_inj_pos = 4'd0; cfg_inj_period = 8'd1;
    in_valid = 1'b1; in_data = 11'h001;
    @(negedge clk);
    checks++; if (out_code[15:1] !== 15'h0007) begin errors++; $display("FAIL pos0_code got %h exp 0007", out_code[15:1]); end
    checks++; if (out_inj !== 1'b0) begin errors++; $display("FAIL pos0_inj got %b exp 0", out_inj); end
    checks++; if (dbg_cnt !== 8'd0) begin errors++; $display("FAIL pos0_cnt got %0d exp 0", dbg_cnt); end
    cfg_inj_pos = 4'd3; cfg_inj_period = 8'd0; in_data = 11'h000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (out_code[15:1] !== 15'h0004) begin errors++; $display("FAIL per0_code[%0d] got %h exp 0004", k, out_code[15:1]); end
      checks++; if (out_inj !== 1'b1) begin errors++; $display("FAIL per0_inj[%0d] got %b exp 1", k, out_inj); end
    end
    checks++; if (stat_inj_cnt !== 16'd4) begin errors++; $display("FAIL per0_stat got %0d exp 4", stat_inj_cnt); end
    in_valid = 1'b0; cfg_inj_en = 1'b0; cfg_inj_pos = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 11'h001;
    @(negedge clk);
    checks++; if (out_code[15:1] !== 15'h0007) begin errors++; $display("FAIL bp_first got %h exp 0007", out_code[15:1]); end
    out_ready = 1'b0; in_data = 11'h002;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", c, in_ready); end
      checks++; if (out_code[15:1] !== 15'h0007) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 0007", c, out_code[15:1]); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_nogap got %b exp 1", out_valid); end
    checks++; if (out_code[15:1] !== 15'h0019) begin errors++; $display("FAIL bp_next got %h exp 0019", out_code[15:1]); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cfg_inj_en = 1'b1; cfg_inj_pos = 4'd5; cfg_inj_period = 8'd4;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 11'h001;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_pre got %b exp 1", out_valid); end
    checks++; if (dbg_cnt !== 8'd2) begin errors++; $display("FAIL mid_cnt_pre got %0d exp 2", dbg_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (dbg_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", dbg_cnt); end
    checks++; if (stat_inj_cnt !== 16'd0) begin errors++; $display("FAIL mid_stat got %0d exp 0", stat_inj_cnt); end
    rst_n = 1'b1; cfg_inj_en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef HAMMING_SECDED_EN
  task automatic test_secded();
    logic [3:0] syn;
    logic       par;
    cfg_inj_en = 1'b1; cfg_inj_pos = 4'd7; cfg_inj_period = 8'd1;
    in_valid = 1'b1; in_data = 11'h001;
    @(negedge clk);
    in_valid = 1'b0; cfg_inj_en = 1'b0;
    syn = '0; par = out_code[0];
    for (int p = 1; p <= 15; p++) begin
      if (out_code[p]) syn = syn ^ 4'(p);
      par = par ^ out_code[p];
    end
    checks++; if (out_code !== 16'h008F) begin errors++; $display("FAIL sec_code got %h exp 008F", out_code); end
    checks++; if (syn !== 4'd7) begin errors++; $display("FAIL sec_syndrome got %0d exp 7", syn); end
    checks++; if (par !== 1'b1) begin errors++; $display("FAIL sec_parity got %b exp 1", par); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_encode();
    test_inject();
    test_pos_zero_period_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef HAMMING_SECDED_EN
    test_secded();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
